// File: rtl/recovery_request_arbiter.sv
// rtl/recovery_request_arbiter.sv - picks the oldest RW/commit recovery request and issues one registered pulse per recovery
module recovery_request_arbiter #(
  parameter int unsigned NUM_RW_PORTS = 2,
  parameter int unsigned AL_IDX_W     = 6,
  parameter int unsigned PC_W         = 32,
  parameter int unsigned RT_W         = 3,
  parameter int unsigned CAUSE_W      = 4,
  parameter int unsigned HOLD_CNT_W   = 8,
  parameter logic [(2**RT_W)-1:0] CSR_RT_MASK = {2'b11, {((2**RT_W)-2){1'b0}}}
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_RW_PORTS-1:0]      rw_req,
  input  logic [NUM_RW_PORTS*AL_IDX_W-1:0] rw_ptr,
  input  logic [NUM_RW_PORTS*PC_W-1:0] rw_pc,
  input  logic [NUM_RW_PORTS*RT_W-1:0] rw_refetch_type,
  input  logic                         cm_req,
  input  logic [AL_IDX_W-1:0]          cm_ptr,
  input  logic [PC_W-1:0]              cm_pc,
  input  logic [RT_W-1:0]              cm_refetch_type,
  input  logic [CAUSE_W-1:0]           cm_cause,
  input  logic [PC_W-1:0]              cm_fault_addr,
  input  logic [AL_IDX_W-1:0]          al_head_ptr,
  input  logic                         unable_to_start,
  input  logic                         to_commit_phase,
  output logic                         out_rw_valid,
  output logic                         out_cm_valid,
  output logic [AL_IDX_W-1:0]          out_ptr,
  output logic [PC_W-1:0]              out_pc,
  output logic [RT_W-1:0]              out_refetch_type,
  output logic [CAUSE_W-1:0]           out_cause,
  output logic [PC_W-1:0]              out_fault_addr,
  output logic                         busy,
  output logic [HOLD_CNT_W-1:0]        hold_cycles
);

  typedef enum logic [1:0] {IDLE, HOLD, RECOVERING} state_e;

  typedef struct packed {
    logic                cm;
    logic [AL_IDX_W-1:0] ptr;
    logic [PC_W-1:0]     pc;
    logic [RT_W-1:0]     rt;
    logic [CAUSE_W-1:0]  cause;
    logic [PC_W-1:0]     fault_addr;
  } req_t;

  state_e                state_q, state_d;
  logic                  pend_v_q, pend_v_d;
  req_t                  pend_q, pend_d;
  logic [HOLD_CNT_W-1:0] hold_q, hold_d;
  logic                  out_rw_q, out_rw_d, out_cm_q, out_cm_d;
  req_t                  out_q, out_d;

  logic                  rw_v, win_v, issue;
  logic [AL_IDX_W-1:0]   rw_age, lane_ptr, lane_age;
  req_t                  rw_best, win;

  // Strict '<' keeps the pending entry on equal age, then the lower lane.
  always_comb begin
    rw_v     = pend_v_q && !pend_q.cm;
    rw_best  = pend_q;
    rw_age   = pend_q.ptr - al_head_ptr;
    lane_ptr = '0;
    lane_age = '0;
    for (int i = 0; i < NUM_RW_PORTS; i++) begin
      lane_ptr = rw_ptr[i*AL_IDX_W +: AL_IDX_W];
      lane_age = lane_ptr - al_head_ptr;
      if (rw_req[i] && (!rw_v || (lane_age < rw_age))) begin
        rw_v               = 1'b1;
        rw_age             = lane_age;
        rw_best.cm         = 1'b0;
        rw_best.ptr        = lane_ptr;
        rw_best.pc         = rw_pc[i*PC_W +: PC_W];
        rw_best.rt         = rw_refetch_type[i*RT_W +: RT_W];
        rw_best.cause      = '0;
        rw_best.fault_addr = '0;
      end
    end

    win_v = 1'b0;
    win   = '0;
    if (pend_v_q && pend_q.cm) begin
      win_v = 1'b1;
      win   = pend_q;
    end else if (cm_req) begin
      win_v = 1'b1;
      win   = '{cm: 1'b1, ptr: cm_ptr, pc: cm_pc, rt: cm_refetch_type,
                cause: cm_cause, fault_addr: cm_fault_addr};
    end else if (rw_v) begin
      win_v = 1'b1;
      win   = rw_best;
      win.cause      = '0;
      win.fault_addr = '0;
    end
  end

  always_comb begin
    state_d  = state_q;
    pend_v_d = pend_v_q;
    pend_d   = pend_q;
    hold_d   = hold_q;
    issue    = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_v) begin
          if (!unable_to_start) begin
            issue   = 1'b1;
            state_d = RECOVERING;
          end else begin
            pend_v_d = 1'b1;
            pend_d   = win;
            hold_d   = HOLD_CNT_W'(1);
            state_d  = HOLD;
          end
        end
      end
      HOLD: begin
        if (unable_to_start) begin
          pend_d = win;
          hold_d = (&hold_q) ? hold_q : hold_q + HOLD_CNT_W'(1);
        end else begin
          issue    = 1'b1;
          pend_v_d = 1'b0;
          hold_d   = '0;
          state_d  = RECOVERING;
        end
      end
      RECOVERING: begin
        if (to_commit_phase) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    out_rw_d = issue && !win.cm;
    out_cm_d = issue && win.cm;
    out_d    = issue ? win : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      pend_v_q <= 1'b0;
      pend_q   <= '0;
      hold_q   <= '0;
      out_rw_q <= 1'b0;
      out_cm_q <= 1'b0;
      out_q    <= '0;
    end else begin
      state_q  <= state_d;
      pend_v_q <= pend_v_d;
      pend_q   <= pend_d;
      hold_q   <= hold_d;
      out_rw_q <= out_rw_d;
      out_cm_q <= out_cm_d;
      out_q    <= out_d;
    end
  end

  assign out_rw_valid     = out_rw_q;
  assign out_cm_valid     = out_cm_q;
  assign out_ptr          = out_q.ptr;
  assign out_pc           = out_q.pc;
  assign out_refetch_type = out_q.rt;
  assign out_cause        = out_q.cause;
  assign out_fault_addr   = out_q.fault_addr;
  assign busy             = (state_q != IDLE);
  assign hold_cycles      = hold_q;

  // The commit stage must not raise a new recovery while one is in progress.
  a_no_cm_in_recovery: assert property (@(posedge clk) disable iff (!rst)
    !((state_q == RECOVERING) && cm_req));

  a_no_csr_rw_issue: assert property (@(posedge clk) disable iff (!rst)
    !(issue && !win.cm && CSR_RT_MASK[win.rt]));

endmodule

// File: tb/tb_recovery_request_arbiter.sv
// tb/tb_recovery_request_arbiter.sv - directed self-checking bench for recovery_request_arbiter
module tb_recovery_request_arbiter;

  localparam int NP = 2;
  localparam int AW = 6;
  localparam int PW = 32;
  localparam int RW = 3;
  localparam int CW = 4;
  localparam int HW = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [NP-1:0]  rw_req;
  logic [NP*AW-1:0] rw_ptr;
  logic [NP*PW-1:0] rw_pc;
  logic [NP*RW-1:0] rw_refetch_type;
  logic           cm_req;
  logic [AW-1:0]  cm_ptr;
  logic [PW-1:0]  cm_pc;
  logic [RW-1:0]  cm_refetch_type;
  logic [CW-1:0]  cm_cause;
  logic [PW-1:0]  cm_fault_addr;
  logic [AW-1:0]  al_head_ptr;
  logic           unable_to_start;
  logic           to_commit_phase;
  logic           out_rw_valid, out_cm_valid, busy;
  logic [AW-1:0]  out_ptr;
  logic [PW-1:0]  out_pc, out_fault_addr;
  logic [RW-1:0]  out_refetch_type;
  logic [CW-1:0]  out_cause;
  logic [HW-1:0]  hold_cycles;

  int checks = 0;
  int failures = 0;

  recovery_request_arbiter dut (
    .clk(clk), .rst(rst), .rw_req(rw_req), .rw_ptr(rw_ptr), .rw_pc(rw_pc),
    .rw_refetch_type(rw_refetch_type), .cm_req(cm_req), .cm_ptr(cm_ptr),
    .cm_pc(cm_pc), .cm_refetch_type(cm_refetch_type), .cm_cause(cm_cause),
    .cm_fault_addr(cm_fault_addr), .al_head_ptr(al_head_ptr),
    .unable_to_start(unable_to_start), .to_commit_phase(to_commit_phase),
    .out_rw_valid(out_rw_valid), .out_cm_valid(out_cm_valid), .out_ptr(out_ptr),
    .out_pc(out_pc), .out_refetch_type(out_refetch_type), .out_cause(out_cause),
    .out_fault_addr(out_fault_addr), .busy(busy), .hold_cycles(hold_cycles)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rw_req = '0; rw_ptr = '0; rw_pc = '0; rw_refetch_type = '0;
    cm_req = 1'b0; cm_ptr = '0; cm_pc = '0; cm_refetch_type = '0;
    cm_cause = '0; cm_fault_addr = '0; to_commit_phase = 1'b0;
  endtask

  task automatic set_lane(input int lane, input logic [AW-1:0] ptr, input logic [PW-1:0] pc);
    rw_req[lane] = 1'b1;
    rw_ptr[lane*AW +: AW] = ptr;
    rw_pc[lane*PW +: PW] = pc;
  endtask

  task automatic finish_recovery();
    clear_inputs();
    to_commit_phase = 1'b1;
    step();
    to_commit_phase = 1'b0;
    check_eq("back_to_idle", busy, 1'b0);
  endtask

  initial begin
    clear_inputs();
    al_head_ptr = '0;
    unable_to_start = 1'b0;
    rst = 1'b0;
    #12;
    check_eq("rst_rw_valid", out_rw_valid, 1'b0);
    check_eq("rst_cm_valid", out_cm_valid, 1'b0);
    check_eq("rst_ptr", out_ptr, 0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_hold", hold_cycles, 0);
    step();
    rst = 1'b1;
    step();

    // single RW request
    set_lane(0, 6'd5, 32'h1000);
    step();
    check_eq("t1_rw_valid", out_rw_valid, 1'b1);
    check_eq("t1_cm_valid", out_cm_valid, 1'b0);
    check_eq("t1_ptr", out_ptr, 5);
    check_eq("t1_pc", out_pc, 32'h1000);
    check_eq("t1_cause", out_cause, 0);
    check_eq("t1_busy", busy, 1'b1);
    clear_inputs();
    step();
    check_eq("t1_pulse_drop", out_rw_valid, 1'b0);
    check_eq("t1_ptr_zero", out_ptr, 0);
    check_eq("t1_still_busy", busy, 1'b1);
    finish_recovery();

    // wrap-around age: head=60, lane1 ptr=62 is older
    al_head_ptr = 6'd60;
    set_lane(0, 6'd2, 32'h2000);
    set_lane(1, 6'd62, 32'h3000);
    step();
    check_eq("t2_rw_valid", out_rw_valid, 1'b1);
    check_eq("t2_ptr", out_ptr, 62);
    check_eq("t2_pc", out_pc, 32'h3000);
    finish_recovery();

    // equal age: lower lane wins
    al_head_ptr = '0;
    set_lane(0, 6'd20, 32'h111);
    set_lane(1, 6'd20, 32'h222);
    step();
    check_eq("tie_pc", out_pc, 32'h111);
    finish_recovery();

    // hold then displace
    unable_to_start = 1'b1;
    set_lane(0, 6'd10, 32'hA0);
    step();
    check_eq("t3_hold_enter", hold_cycles, 1);
    check_eq("t3_no_pulse", out_rw_valid, 1'b0);
    check_eq("t3_busy", busy, 1'b1);
    clear_inputs();
    step();
    step();
    set_lane(0, 6'd4, 32'h40);
    step();
    clear_inputs();
    step();
    step();
    check_eq("t3_hold_at_decision", hold_cycles, 6);
    unable_to_start = 1'b0;
    step();
    check_eq("t3_rw_valid", out_rw_valid, 1'b1);
    check_eq("t3_ptr", out_ptr, 4);
    check_eq("t3_pc", out_pc, 32'h40);
    check_eq("t3_hold_clear", hold_cycles, 0);
    finish_recovery();

    // pending beats new on equal age
    unable_to_start = 1'b1;
    set_lane(1, 6'd5, 32'h500);
    step();
    clear_inputs();
    set_lane(0, 6'd5, 32'h501);
    unable_to_start = 1'b0;
    step();
    check_eq("pend_tie_pc", out_pc, 32'h500);
    finish_recovery();

    // commit priority over a pending older RW request
    unable_to_start = 1'b1;
    set_lane(0, 6'd1, 32'h10);
    step();
    clear_inputs();
    cm_req = 1'b1; cm_ptr = 6'd3; cm_pc = 32'h300; cm_cause = 4'd5;
    cm_fault_addr = 32'hDEAD; cm_refetch_type = 3'd6;
    unable_to_start = 1'b0;
    step();
    check_eq("t4_cm_valid", out_cm_valid, 1'b1);
    check_eq("t4_rw_valid", out_rw_valid, 1'b0);
    check_eq("t4_ptr", out_ptr, 3);
    check_eq("t4_pc", out_pc, 32'h300);
    check_eq("t4_cause", out_cause, 5);
    check_eq("t4_fault", out_fault_addr, 32'hDEAD);
    check_eq("t4_rt", out_refetch_type, 6);
    finish_recovery();

    // RECOVERING drops RW requests, including on the to_commit_phase cycle
    set_lane(0, 6'd7, 32'h70);
    step();
    check_eq("t5_issue", out_rw_valid, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("t5_dropped", out_rw_valid, 1'b0);
    end
    to_commit_phase = 1'b1;
    step();
    to_commit_phase = 1'b0;
    check_eq("t5_exit_no_pulse", out_rw_valid, 1'b0);
    check_eq("t5_idle", busy, 1'b0);
    clear_inputs();
    step();
    check_eq("t5_stale_ignored", out_rw_valid, 1'b0);
    set_lane(0, 6'd8, 32'h80);
    step();
    check_eq("t5_reissue", out_rw_valid, 1'b1);
    check_eq("t5_reissue_ptr", out_ptr, 8);
    finish_recovery();

    // saturating hold counter
    unable_to_start = 1'b1;
    set_lane(0, 6'd9, 32'h90);
    step();
    clear_inputs();
    repeat (300) step();
    check_eq("hold_saturate", hold_cycles, 8'hFF);

    // async reset while holding
    #2 rst = 1'b0;
    #1;
    check_eq("t6_busy", busy, 1'b0);
    check_eq("t6_hold", hold_cycles, 0);
    check_eq("t6_rw_valid", out_rw_valid, 1'b0);
    unable_to_start = 1'b0;
    step();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("t6_no_pulse", out_rw_valid | out_cm_valid, 1'b0);
      check_eq("t6_idle", busy, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
